elevador_registro_llamadas: RTL and testbench

- Input conditioning stage directly upstream of Elevador_3pisos.
- Synchronises and debounces the three raw hall buttons and three raw floor sensors.
- Latches button presses as pending calls and drives them as the p1..p3 / f1..f3 inputs of the elevator controller.
- Also reports the last confirmed floor and flags an inconsistent sensor pattern.

---
 rtl/elevador_registro_llamadas.sv | 106 ++++++++++
 tb/tb_elevador_registro_llamadas.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/elevador_registro_llamadas.sv
// Input conditioning for Elevador_3pisos: synchronises and debounces hall buttons and floor
// sensors, latches pending calls, tracks the last confirmed floor and flags sensor conflicts.
module elevador_registro_llamadas #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic [1:0] piso_actual,
  output logic       error_sensor
);

  localparam int NCH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync_p0;
  logic [NCH-1:0]   sync_p1;
  logic [NCH-1:0]   clean;
  logic [CNT_W-1:0] cnt [NCH];
  logic [2:0]       btn_d;
  logic [2:0]       press;
  logic [2:0]       fl;
  logic [2:0]       call;
  logic [1:0]       piso;
  logic             err;

  // Channels 0..2 are buttons b1..b3, channels 3..5 are sensors s1..s3.
  assign raw = {s3, s2, s1, b3, b2, b1};

  // Two-flop synchroniser per channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: clean follows sync only after DEBOUNCE_CYCLES consecutive disagreeing clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clean <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_p1[i] == clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          clean[i] <= sync_p1[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fl    = clean[5:3];
  assign press = clean[2:0] & ~btn_d;

  // Call latch and floor tracking, one clock after the clean values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_d <= '0;
      call  <= '0;
      piso  <= 2'd0;
      err   <= 1'b0;
    end else begin
      btn_d <= clean[2:0];
      // Arrival at a floor clears its call and wins over a simultaneous press.
      call  <= (call | (press & ~fl)) & ~fl;
      err   <= (fl[0] & fl[1]) | (fl[0] & fl[2]) | (fl[1] & fl[2]);
      unique case (fl)
        3'b001:  piso <= 2'd1;
        3'b010:  piso <= 2'd2;
        3'b100:  piso <= 2'd3;
        default: piso <= piso;
      endcase
    end
  end

  assign p1           = call[0];
  assign p2           = call[1];
  assign p3           = call[2];
  assign f1           = fl[0];
  assign f2           = fl[1];
  assign f3           = fl[2];
  assign piso_actual  = piso;
  assign error_sensor = err;

endmodule

// File: tb/tb_elevador_registro_llamadas.sv
// Directed bench for elevador_registro_llamadas: stimulus queues hand-computed expectations
// tagged with the clock edge they apply to; a negedge monitor pops and compares them.
module tb_elevador_registro_llamadas;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
  logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic       p1, p2, p3, f1, f2, f3;
  logic [1:0] piso_actual;
  logic       error_sensor;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;

  int         q_edge [$];
  logic [8:0] q_val  [$];
  string      q_name [$];

  elevador_registro_llamadas #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .b1(b1), .b2(b2), .b3(b3),
    .s1(s1), .s2(s2), .s3(s3),
    .p1(p1), .p2(p2), .p3(p3),
    .f1(f1), .f2(f2), .f3(f3),
    .piso_actual(piso_actual), .error_sensor(error_sensor)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [8:0] v(input logic c1, input logic c2, input logic c3,
                                   input logic g1, input logic g2, input logic g3,
                                   input logic [1:0] pa, input logic e);
    return {c1, c2, c3, g1, g2, g3, pa, e};
  endfunction

  task automatic exp_at(input int off, input logic [8:0] val, input string name);
    q_edge.push_back(ecnt + off);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation whose edge has arrived
  always @(negedge clk) begin
    logic [8:0] act;
    act = {p1, p2, p3, f1, f2, f3, piso_actual, error_sensor};
    for (int i = q_edge.size() - 1; i >= 0; i--) begin
      if (q_edge[i] <= ecnt) begin
        checks = checks + 1;
        if (q_edge[i] < ecnt) begin
          errors = errors + 1;
          $display("FAIL %s: missed edge %0d (now %0d)", q_name[i], q_edge[i], ecnt);
        end else if (act !== q_val[i]) begin
          errors = errors + 1;
          $display("FAIL %s edge=%0d {p1p2p3,f1f2f3,piso,err} got=%b expected=%b",
                   q_name[i], ecnt, act, q_val[i]);
        end
        q_edge.delete(i);
        q_val.delete(i);
        q_name.delete(i);
      end
    end
  end

  initial begin
    // Reset with cabin sensed at floor 1
    s1 = 1'b1;
    step(2);
    exp_at(0, v(0,0,0,0,0,0,2'd0,0), "rst_hold_a");
    step(1);
    exp_at(0, v(0,0,0,0,0,0,2'd0,0), "rst_hold_b");
    step(1);
    reset = 1'b1;
    exp_at(5, v(0,0,0,0,0,0,2'd0,0), "rel_e5");
    exp_at(6, v(0,0,0,1,0,0,2'd0,0), "rel_f1");
    exp_at(7, v(0,0,0,1,0,0,2'd1,0), "rel_piso1");
    step(10);

    // b3 call from floor 1, then travel to floor 3
    b3 = 1'b1;
    exp_at(6, v(0,0,0,1,0,0,2'd1,0), "b3_pre");
    exp_at(7, v(0,0,1,1,0,0,2'd1,0), "b3_call");
    step(15);
    b3 = 1'b0;
    exp_at(10, v(0,0,1,1,0,0,2'd1,0), "b3_hold");
    step(10);
    s1 = 1'b0;
    exp_at(7, v(0,0,1,0,0,0,2'd1,0), "between_hold");
    step(10);
    s3 = 1'b1;
    exp_at(6, v(0,0,1,0,0,1,2'd1,0), "f3_up");
    exp_at(7, v(0,0,0,0,0,1,2'd3,0), "p3_clear");
    step(10);

    // b2 bounce is rejected, steady press is accepted
    for (int k = 0; k < 3; k++) begin
      b2 = 1'b1;
      step(2);
      b2 = 1'b0;
      step(1);
    end
    exp_at(8, v(0,0,0,0,0,1,2'd3,0), "bounce_rej");
    step(10);
    b2 = 1'b1;
    exp_at(6, v(0,0,0,0,0,1,2'd3,0), "b2_pre");
    exp_at(7, v(0,1,0,0,0,1,2'd3,0), "b2_call");
    step(10);
    b2 = 1'b0;
    step(10);

    // Travel 3 -> 2 (clears p2) -> 1
    s3 = 1'b0;
    exp_at(7, v(0,1,0,0,0,0,2'd3,0), "leave3");
    step(10);
    s2 = 1'b1;
    exp_at(7, v(0,0,0,0,1,0,2'd2,0), "arrive2");
    step(10);
    s2 = 1'b0;
    s1 = 1'b1;
    exp_at(6, v(0,0,0,1,0,0,2'd2,0), "move1_f");
    exp_at(7, v(0,0,0,1,0,0,2'd1,0), "arrive1");
    step(10);

    // Press at current floor is ignored
    b1 = 1'b1;
    exp_at(7,  v(0,0,0,1,0,0,2'd1,0), "b1_ignored_e7");
    exp_at(10, v(0,0,0,1,0,0,2'd1,0), "b1_ignored_e10");
    step(10);
    b1 = 1'b0;
    step(10);

    // Simultaneous presses latch on the same edge
    b2 = 1'b1;
    b3 = 1'b1;
    exp_at(6, v(0,0,0,1,0,0,2'd1,0), "dual_pre");
    exp_at(7, v(0,1,1,1,0,0,2'd1,0), "dual_call");
    step(10);
    b2 = 1'b0;
    b3 = 1'b0;
    step(10);

    // Two sensors high: error, floor holds; both calls clear
    s1 = 1'b0;
    s2 = 1'b1;
    s3 = 1'b1;
    exp_at(6, v(0,1,1,0,1,1,2'd1,0), "multi_f");
    exp_at(7, v(0,0,0,0,1,1,2'd1,1), "err_set");
    step(12);
    exp_at(0, v(0,0,0,0,1,1,2'd1,1), "err_stable");
    s3 = 1'b0;
    exp_at(6, v(0,0,0,0,1,0,2'd1,1), "err_lag");
    exp_at(7, v(0,0,0,0,1,0,2'd2,0), "err_clear");
    step(10);

    // Pending p3 dropped by asynchronous mid-cycle reset
    b3 = 1'b1;
    exp_at(7, v(0,0,1,0,1,0,2'd2,0), "p3_pend");
    step(10);
    b3 = 1'b0;
    step(10);
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_at(0, v(0,0,0,0,0,0,2'd0,0), "async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_at(5,  v(0,0,0,0,0,0,2'd0,0), "rst_e5");
    exp_at(6,  v(0,0,0,0,1,0,2'd0,0), "rst_f2");
    exp_at(7,  v(0,0,0,0,1,0,2'd2,0), "rst_piso2");
    exp_at(12, v(0,0,0,0,1,0,2'd2,0), "no_recall");
    step(15);

    step(2);
    for (int i = 0; i < q_edge.size(); i++) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: never checked (edge %0d)", q_name[i], q_edge[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
